// File: rtl/secded_pkg.sv
// Shared definitions for the Hamming(72,64) SECDED encoder and decoder:
// code geometry, injection modes, data-to-position mapping and check-bit masks.
package secded_pkg;

   localparam int DATA_W = 64;
   localparam int CODE_W = 72;
   localparam int CHK_W  = 7;

   typedef enum logic [1:0] {
      INJ_NONE   = 2'b00,
      INJ_SINGLE = 2'b01,
      INJ_DOUBLE = 2'b10,
      INJ_RSVD   = 2'b11
   } inj_mode_t;

   typedef logic [CHK_W-1:0][DATA_W-1:0] chk_masks_t;

   // Data bits occupy every non-power-of-two position from 3 upward, in order.
   function automatic logic [6:0] data_pos(input int idx);
      int         n;
      logic [6:0] p;
      n = 0;
      p = '0;
      for (int q = 3; q < CODE_W; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (n == idx) p = 7'(q);
            n++;
         end
      end
      return p;
   endfunction

   function automatic logic [6:0] chk_pos(input int k);
      return 7'(1 << k);
   endfunction

   function automatic chk_masks_t build_masks();
      chk_masks_t m;
      logic [6:0] p;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         p = data_pos(i);
         for (int k = 0; k < CHK_W; k++) m[k][i] = p[k];
      end
      return m;
   endfunction

   localparam chk_masks_t CHK_MASKS = build_masks();

   // Places data and check bits, then sets position 0 for even overall parity.
   function automatic logic [CODE_W-1:0] assemble_code(input logic [DATA_W-1:0] data,
                                                       input logic [CHK_W-1:0]  chk);
      logic [CODE_W-1:0] code;
      code = '0;
      for (int i = 0; i < DATA_W; i++) code[data_pos(i)] = data[i];
      for (int k = 0; k < CHK_W; k++) code[chk_pos(k)] = chk[k];
      code[0] = ^code[CODE_W-1:1];
      return code;
   endfunction

endpackage

// File: rtl/secded_enc_comb.sv
// Combinational Hamming(72,64) SECDED encoder: check bits and full codeword,
// no injection.
module secded_enc_comb
   import secded_pkg::*;
(
   input  logic [63:0] data,
   output logic [6:0]  chk,
   output logic [71:0] code
);

   always_comb begin
      chk = '0;
      for (int k = 0; k < CHK_W; k++) chk[k] = ^(data & CHK_MASKS[k]);
   end

   assign code = assemble_code(data, chk);

endmodule

// File: rtl/secded_enc_72_64.sv
// Two-stage pipelined SECDED(72,64) encoder with per-word error injection
// and a saturating delivered-codeword counter.
module secded_enc_72_64
   import secded_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       inj_mode,
   input  logic [6:0]       inj_pos,
   output logic [71:0]      out_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] word_cnt
);

   // Handshake: a word moves on any edge where valid && ready. Both stages
   // advance together on en; a stalled output freezes the whole pipe.
   logic        en;
   logic [6:0]  enc_chk;
   logic [71:0] enc_code_unused;

   logic        s1_valid;
   logic [63:0] s1_data;
   logic [6:0]  s1_chk;
   inj_mode_t   s1_mode;
   logic [6:0]  s1_pos;

   logic [71:0] s2_code;
   logic [6:0]  pos_nxt;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   secded_enc_comb u_enc (
      .data (in_data),
      .chk  (enc_chk),
      .code (enc_code_unused)
   );

   always_ff @(posedge clk) begin
      if (en) begin
         s1_data <= in_data;
         s1_chk  <= enc_chk;
         s1_mode <= inj_mode_t'(inj_mode);
         s1_pos  <= inj_pos;
      end
   end

   // Injection is applied after parity so the flipped word is a true error.
   always_comb begin
      s2_code = assemble_code(s1_data, s1_chk);
      pos_nxt = (s1_pos == 7'd71) ? 7'd0 : s1_pos + 7'd1;
      if (s1_pos < 7'(CODE_W)) begin
         if (s1_mode == INJ_SINGLE) begin
            s2_code[s1_pos] = ~s2_code[s1_pos];
         end else if (s1_mode == INJ_DOUBLE) begin
            s2_code[s1_pos]  = ~s2_code[s1_pos];
            s2_code[pos_nxt] = ~s2_code[pos_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_code  <= '0;
         word_cnt  <= '0;
      end else begin
         if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            out_code  <= s2_code;
         end
         if (out_valid && out_ready && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_secded_enc_72_64.sv
// Directed bench for secded_enc_72_64: vector table, random words against the
// combinational reference, a stalled stream, and reset while full.
module tb_secded_enc_72_64;

   localparam int TB_CNT_W = 3;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic                clk;
   logic                rst_n;
   logic [63:0]         in_data;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          inj_mode;
   logic [6:0]          inj_pos;
   logic [71:0]         out_code;
   logic                out_valid;
   logic                out_ready;
   logic [TB_CNT_W-1:0] word_cnt;

   logic [63:0]         ref_data;
   logic [6:0]          ref_chk_unused;
   logic [71:0]         ref_code;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  mode;
      logic [6:0]  pos;
      logic [71:0] exp;
   } vec_t;

   vec_t        vecs[10];
   logic [71:0] exp_q[$];
   logic [63:0] stream_words[4];
   logic [71:0] stream_exp[4];

   secded_enc_72_64 #(.CNT_W(TB_CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inj_mode  (inj_mode),
      .inj_pos   (inj_pos),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_cnt  (word_cnt)
   );

   secded_enc_comb u_ref (
      .data (ref_data),
      .chk  (ref_chk_unused),
      .code (ref_code)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One isolated word; called at a negedge, returns at a negedge.
   task automatic run_vec(input string name, input logic [63:0] data, input logic [1:0] mode,
                          input logic [6:0] pos, input logic [71:0] exp);
      in_valid = 1'b1;
      in_data  = data;
      inj_mode = mode;
      inj_pos  = pos;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, 72'(out_valid), 72'd1);
      check({name, "_code"}, out_code, exp);
      @(negedge clk);
      exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
      check({name, "_cnt"}, 72'(word_cnt), 72'(exp_cnt));
      check({name, "_drain"}, 72'(out_valid), 72'd0);
   endtask

   initial begin
      int sent;
      int got;
      int stall_left;
      int cyc;
      bit stall_done;
      logic [6:0] rpos;

      vecs[0] = '{64'h0,                   2'b00, 7'd0,   72'h00_0000_0000_0000_0000};
      vecs[1] = '{64'h1,                   2'b00, 7'd0,   72'h00_0000_0000_0000_000F};
      vecs[2] = '{64'h8000_0000_0000_0000, 2'b00, 7'd0,   72'h81_0000_0000_0000_0017};
      vecs[3] = '{64'h1,                   2'b01, 7'd5,   72'h00_0000_0000_0000_002F};
      vecs[4] = '{64'h1,                   2'b10, 7'd71,  72'h80_0000_0000_0000_000E};
      vecs[5] = '{64'h1,                   2'b01, 7'd72,  72'h00_0000_0000_0000_000F};
      vecs[6] = '{64'h1,                   2'b11, 7'd5,   72'h00_0000_0000_0000_000F};
      vecs[7] = '{64'h2,                   2'b10, 7'd127, 72'h00_0000_0000_0000_0033};
      vecs[8] = '{64'h2,                   2'b10, 7'd0,   72'h00_0000_0000_0000_0030};
      vecs[9] = '{64'h2,                   2'b01, 7'd70,  72'h40_0000_0000_0000_0033};

      stream_words = '{64'h0, 64'h1, 64'h2, 64'h8000_0000_0000_0000};
      stream_exp   = '{72'h00_0000_0000_0000_0000, 72'h00_0000_0000_0000_000F,
                       72'h00_0000_0000_0000_0033, 72'h81_0000_0000_0000_0017};

      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      inj_mode  = 2'b00;
      inj_pos   = '0;
      out_ready = 1'b1;
      ref_data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_out_valid", 72'(out_valid), 72'd0);
      check("rst_out_code", out_code, 72'h0);
      check("rst_word_cnt", 72'(word_cnt), 72'd0);
      check("rst_in_ready", 72'(in_ready), 72'd1);

      // vector table; counter saturates at CNT_MAX along the way
      for (int i = 0; i < 10; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, vecs[i].pos, vecs[i].exp);

      // random payloads with a single flip, expected from the reference encoder
      for (int r = 0; r < 6; r++) begin
         ref_data = {$urandom, $urandom};
         rpos     = 7'($urandom_range(0, 71));
         #1;
         run_vec($sformatf("rnd%0d", r), ref_data, 2'b01, rpos, ref_code ^ (72'd1 << rpos));
      end

      // stream of 4 with a 3-cycle output stall after the first word shows up
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      check("stream_cnt_clear", 72'(word_cnt), 72'd0);
      inj_mode   = 2'b00;
      sent       = 0;
      got        = 0;
      stall_left = 0;
      stall_done = 1'b0;
      cyc        = 0;
      while (got < 4 && cyc < 60) begin
         @(negedge clk);
         if (out_valid && !stall_done) begin
            stall_done = 1'b1;
            stall_left = 3;
         end
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         in_valid = (sent < 4);
         in_data  = (sent < 4) ? stream_words[sent] : 64'h0;
         #1;
         if (out_valid && exp_q.size() == 0) begin
            check("stream_extra_word", out_code, 72'h0);
            got++;
         end else if (out_valid && !out_ready) begin
            check("stall_in_ready", 72'(in_ready), 72'd0);
            check("stall_hold_code", out_code, exp_q[0]);
         end else if (out_valid && out_ready) begin
            check($sformatf("stream_word%0d", got), out_code, exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(stream_exp[sent]);
            sent++;
         end
         cyc++;
      end
      check("stream_got", 72'(got), 72'd4);
      check("stream_q_empty", 72'(exp_q.size()), 72'd0);
      check("stream_stalled", 72'(stall_done), 72'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("stream_cnt", 72'(word_cnt), 72'd4);
      check("stream_drain", 72'(out_valid), 72'd0);

      // fill both stages under stall, then reset
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h1;
      @(negedge clk);
      in_data = 64'h2;
      @(negedge clk);
      in_valid = 1'b0;
      check("full_in_ready", 72'(in_ready), 72'd0);
      check("full_out_code", out_code, 72'h00_0000_0000_0000_000F);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check("mid_rst_out_valid", 72'(out_valid), 72'd0);
      check("mid_rst_out_code", out_code, 72'h0);
      check("mid_rst_word_cnt", 72'(word_cnt), 72'd0);
      check("mid_rst_in_ready", 72'(in_ready), 72'd1);
      @(negedge clk);
      check("mid_rst_s1_flushed", 72'(out_valid), 72'd0);
      exp_cnt = 0;
      run_vec("post_rst", 64'h8000_0000_0000_0000, 2'b00, 7'd0, 72'h81_0000_0000_0000_0017);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
